// File: rtl/cci_test_flow_throttle.sv
// Per-channel active-line tracker with almost-full throttle FSM.
// Tracks outstanding lines, peak and sticky over/underflow per channel.
module cci_test_flow_throttle #(
  parameter int N_CHAN        = 2,
  parameter int CNT_W         = 10,
  parameter int MAX_REQ_LINES = 4,
  localparam int LW = (MAX_REQ_LINES > 1) ? $clog2(MAX_REQ_LINES) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              mode,
  input  logic [N_CHAN*CNT_W-1:0] limit_hi,
  input  logic [N_CHAN*CNT_W-1:0] limit_lo,
  input  logic                    clr_stats,
  input  logic [N_CHAN-1:0]       req_valid,
  input  logic [N_CHAN*LW-1:0]    req_len,
  input  logic [N_CHAN-1:0]       rsp_valid,
  output logic [N_CHAN-1:0]       force_alm_full,
  output logic [N_CHAN*CNT_W-1:0] active_cnt,
  output logic [N_CHAN*CNT_W-1:0] peak_cnt,
  output logic [N_CHAN-1:0]       err_ovf,
  output logic [N_CHAN-1:0]       err_unf
);

  localparam int SW = CNT_W + 2;

  typedef enum logic {
    OPEN     = 1'b0,
    THROTTLE = 1'b1
  } st_e;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] peak_q, peak_d;
    logic [CNT_W-1:0] hi, lo;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_ev, unf_ev;
    logic             thr;
    logic [LW:0]      inc;
    logic [SW-1:0]    sum;
    st_e              st_q, st_d;

    always_comb begin
      hi     = limit_hi[c*CNT_W +: CNT_W];
      lo     = limit_lo[c*CNT_W +: CNT_W];
      inc    = '0;
      if (req_valid[c])
        inc = {1'b0, req_len[c*LW +: LW]} + 1'b1;
      sum    = {2'b00, cnt_q} + SW'(inc) - SW'(rsp_valid[c]);
      cnt_d  = sum[CNT_W-1:0];
      ovf_ev = 1'b0;
      unf_ev = 1'b0;
      // top bit set means the signed sum went negative
      if (sum[CNT_W+1]) begin
        cnt_d  = '0;
        unf_ev = 1'b1;
      end else if (sum[CNT_W]) begin
        cnt_d  = '1;
        ovf_ev = 1'b1;
      end
      peak_d = (cnt_d > peak_q) ? cnt_d : peak_q;
      ovf_d  = ovf_q | ovf_ev;
      unf_d  = unf_q | unf_ev;
      if (clr_stats) begin
        peak_d = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
      end
      thr  = (cnt_d >= hi);
      st_d = OPEN;
      unique case (1'b1)
        mode == 2'd1: st_d = thr ? THROTTLE : OPEN;
        mode == 2'd2: begin
          if (st_q == OPEN || lo >= hi)
            st_d = thr ? THROTTLE : OPEN;
          else
            st_d = (cnt_d <= lo) ? OPEN : THROTTLE;
        end
        default: st_d = OPEN;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        peak_q <= '0;
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
        st_q   <= OPEN;
      end else begin
        cnt_q  <= cnt_d;
        peak_q <= peak_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
        st_q   <= st_d;
      end
    end

    assign force_alm_full[c]          = (st_q == THROTTLE);
    assign active_cnt[c*CNT_W +: CNT_W] = cnt_q;
    assign peak_cnt[c*CNT_W +: CNT_W]   = peak_q;
    assign err_ovf[c]                 = ovf_q;
    assign err_unf[c]                 = unf_q;
  end

endmodule

// File: tb/tb_cci_test_flow_throttle.sv
// Directed bench for cci_test_flow_throttle.
// Second instance uses CNT_W=4 to reach the overflow boundary.
module tb_cci_test_flow_throttle;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  mode;
  logic [19:0] limit_hi, limit_lo;
  logic        clr_stats;
  logic [1:0]  req_valid, rsp_valid;
  logic [3:0]  req_len;
  logic [1:0]  force_alm_full, err_ovf, err_unf;
  logic [19:0] active_cnt, peak_cnt;

  logic [1:0]  mode4;
  logic [7:0]  hi4, lo4;
  logic        clr4;
  logic [1:0]  req4, rsp4;
  logic [3:0]  len4;
  logic [1:0]  faf4, ovf4, unf4;
  logic [7:0]  act4, peak4;

  int errors = 0;
  int checks = 0;

  cci_test_flow_throttle dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .limit_hi(limit_hi), .limit_lo(limit_lo),
    .clr_stats(clr_stats), .req_valid(req_valid),
    .req_len(req_len), .rsp_valid(rsp_valid),
    .force_alm_full(force_alm_full),
    .active_cnt(active_cnt), .peak_cnt(peak_cnt),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  cci_test_flow_throttle #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .mode(mode4),
    .limit_hi(hi4), .limit_lo(lo4),
    .clr_stats(clr4), .req_valid(req4),
    .req_len(len4), .rsp_valid(rsp4),
    .force_alm_full(faf4),
    .active_cnt(act4), .peak_cnt(peak4),
    .err_ovf(ovf4), .err_unf(unf4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mode = 2'd0; limit_hi = '0; limit_lo = '0;
    clr_stats = 1'b0; req_valid = '0;
    req_len = '0; rsp_valid = '0;
    mode4 = 2'd0; hi4 = '0; lo4 = '0; clr4 = 1'b0;
    req4 = '0; len4 = '0; rsp4 = '0;

    #12;
    chk("rst_cnt", active_cnt, 0);
    chk("rst_peak", peak_cnt, 0);
    chk("rst_faf", force_alm_full, 0);
    chk("rst_err", {err_ovf, err_unf}, 0);
    #2 reset_n = 1'b1;
    step();

    // overflow boundary on the 4-bit instance
    req4 = 2'b01; len4 = 4'd3;
    for (int i = 0; i < 3; i++) step();
    chk("o_cnt12", act4[3:0], 12);
    len4 = 4'd1;
    step();
    chk("o_cnt14", act4[3:0], 14);
    len4 = 4'd3;
    step();
    chk("o_cnt15", act4[3:0], 15);
    chk("o_ovf", ovf4[0], 1);
    chk("o_peak", peak4[3:0], 15);
    clr4 = 1'b1;
    step();
    chk("o_clr_cnt", act4[3:0], 15);
    chk("o_clr_peak", peak4[3:0], 0);
    chk("o_clr_ovf", ovf4[0], 0);
    chk("o_ch1", {ovf4[1], act4[7:4]}, 0);
    clr4 = 1'b0; req4 = '0;

    // LIMIT ramp on ch0
    mode = 2'd1;
    limit_hi = {10'd8, 10'd8};
    req_valid = 2'b01; req_len = 4'b0011;
    step();
    chk("l_cnt4", active_cnt[9:0], 4);
    chk("l_faf4", force_alm_full[0], 0);
    step();
    chk("l_cnt8", active_cnt[9:0], 8);
    chk("l_faf8", force_alm_full[0], 1);
    chk("l_ch1", {force_alm_full[1], active_cnt[19:10]}, 0);
    req_valid = '0;

    // HYST drain from 8
    mode = 2'd2;
    limit_lo = {10'd2, 10'd2};
    rsp_valid = 2'b01;
    for (int k = 7; k >= 3; k--) begin
      step();
      chk("h_cnt", active_cnt[9:0], k);
      chk("h_faf_hold", force_alm_full[0], 1);
    end
    step();
    chk("h_cnt2", active_cnt[9:0], 2);
    chk("h_faf_rel", force_alm_full[0], 0);
    rsp_valid = '0;
    req_valid = 2'b01; req_len = 4'b0000;
    step();
    chk("h_cnt3", active_cnt[9:0], 3);
    chk("h_faf3", force_alm_full[0], 0);

    // simultaneous req/rsp, underflow, clear
    req_len = 4'b0001;
    step();
    chk("s_cnt5", active_cnt[9:0], 5);
    rsp_valid = 2'b01;
    step();
    chk("s_cnt6", active_cnt[9:0], 6);
    chk("s_peak", peak_cnt[9:0], 8);
    req_valid = '0;
    for (int i = 0; i < 6; i++) step();
    chk("s_cnt0", active_cnt[9:0], 0);
    chk("s_unf0", err_unf[0], 0);
    step();
    chk("s_cnt_unf", active_cnt[9:0], 0);
    chk("s_unf", err_unf[0], 1);
    rsp_valid = '0; clr_stats = 1'b1;
    step();
    chk("s_clr_unf", err_unf[0], 0);
    chk("s_clr_peak", peak_cnt[9:0], 0);
    clr_stats = 1'b0;

    // edge cases
    mode = 2'd1; limit_hi = '0;
    step();
    chk("e_hi0", force_alm_full, 2'b11);
    mode = 2'd3;
    req_valid = 2'b01; req_len = 4'b0011;
    step();
    chk("e_m3_cnt", active_cnt[9:0], 4);
    chk("e_m3_faf", force_alm_full, 0);

    // async reset mid-burst at count 6
    mode = 2'd1; limit_hi = {10'd8, 10'd6};
    req_len = 4'b0001;
    step();
    chk("r_cnt6", active_cnt[9:0], 6);
    chk("r_faf", force_alm_full[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("r_async_cnt", active_cnt, 0);
    chk("r_async_faf", force_alm_full, 0);
    chk("r_async_peak", peak_cnt, 0);
    mode = 2'd0; req_len = 4'b0010;
    #10 reset_n = 1'b1;
    step();
    chk("r_first", active_cnt[9:0], 3);
    chk("r_noerr", {err_ovf, err_unf}, 0);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
